// File: rtl/pcie_tl_rx_buf.sv
// PCIe transaction-layer receive buffer with header flow-control credit tracking.
// A FIFO holds incoming TLPs; freed slots are advertised to the link partner through InitFC/UpdateFC requests.
module pcie_tl_rx_buf #(
    parameter int TLP_W          = 128,
    parameter int DEPTH          = 8,
    parameter int UPDATE_THRESH  = 4,
    parameter int UPDATE_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tlp_valid_i,
    input  logic [TLP_W-1:0] tlp_i,
    output logic             tlp_ready_o,
    output logic             app_valid_o,
    output logic [TLP_W-1:0] app_tlp_o,
    input  logic             app_ready_i,
    output logic             fc_update_valid_o,
    output logic [7:0]       fc_hdr_credits_o,
    input  logic             fc_update_ready_i,
    output logic             fc_init_done_o,
    output logic             overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(UPDATE_TIMEOUT + 1);
    localparam logic [7:0] DEPTH_CRED = 8'(DEPTH % 256);

    typedef enum logic [1:0] {INIT, IDLE, UPDATE} state_t;

    state_t           state, state_next;
    logic [TLP_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    pending;
    logic [TW-1:0]    timer;
    logic [7:0]       alloc;
    logic [7:0]       credits;
    logic             init_done;
    logic             overflow;
    logic             full, empty, push, pop;
    logic             fc_valid_raw, enter_update;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Outputs are forced to their idle values while reset is held
    assign tlp_ready_o       = !rst && !full && init_done;
    assign app_valid_o       = !rst && !empty;
    assign app_tlp_o         = app_valid_o ? mem[rd_ptr] : '0;
    assign fc_update_valid_o = !rst && fc_valid_raw;
    assign fc_hdr_credits_o  = rst ? 8'd0 : credits;
    assign fc_init_done_o    = init_done;
    assign overflow_o        = overflow;

    assign push         = tlp_valid_i && tlp_ready_o;
    assign pop          = app_valid_o && app_ready_i;
    assign enter_update = (state == IDLE) && (state_next == UPDATE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tlp_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A TLP offered while full means the partner ignored our credits
            if (tlp_valid_i && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            init_done <= 1'b0;
            alloc     <= DEPTH_CRED;
            credits   <= DEPTH_CRED;
            pending   <= '0;
            timer     <= '0;
        end else begin
            state <= state_next;
            if (state == INIT && fc_update_ready_i) begin
                init_done <= 1'b1;
            end
            if (pop) begin
                alloc <= alloc + 8'd1;
            end
            // The advertised value excludes a pop landing in the same cycle; that pop stays pending
            if (enter_update) begin
                credits <= alloc;
                pending <= pop ? CW'(1) : '0;
                timer   <= '0;
            end else begin
                if (pop && pending != CW'(DEPTH)) begin
                    pending <= pending + CW'(1);
                end
                if (state == IDLE && pending != '0 && timer != TW'(UPDATE_TIMEOUT)) begin
                    timer <= timer + TW'(1);
                end
            end
        end
    end

    always_comb begin
        state_next   = state;
        fc_valid_raw = 1'b0;
        case (state)
            INIT: begin
                fc_valid_raw = 1'b1;
                if (fc_update_ready_i) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (pending >= CW'(UPDATE_THRESH) || timer >= TW'(UPDATE_TIMEOUT)) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                fc_valid_raw = 1'b1;
                if (fc_update_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = INIT;
        endcase
    end

endmodule

// File: tb/tb_pcie_tl_rx_buf.sv
// Self-checking bench for pcie_tl_rx_buf: a scoreboard queue tracks accepted TLPs and
// directed phases exercise init, ordering, backpressure, overflow, credit updates and reset.
module tb_pcie_tl_rx_buf;

    logic         clk;
    logic         rst;
    logic         tlpValid;
    logic [127:0] tlpData;
    logic         tlpReady;
    logic         appValid;
    logic [127:0] appTlp;
    logic         appReady;
    logic         fcValid;
    logic [7:0]   fcCredits;
    logic         fcReady;
    logic         initDone;
    logic         overflow;

    int           checks = 0;
    int           errors = 0;
    logic [127:0] expQ[$];
    int           popsSinceReset = 0;
    logic [7:0]   lastCredits = 8'd0;

    pcie_tl_rx_buf #(
        .TLP_W(128),
        .DEPTH(8),
        .UPDATE_THRESH(4),
        .UPDATE_TIMEOUT(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tlp_valid_i(tlpValid),
        .tlp_i(tlpData),
        .tlp_ready_o(tlpReady),
        .app_valid_o(appValid),
        .app_tlp_o(appTlp),
        .app_ready_i(appReady),
        .fc_update_valid_o(fcValid),
        .fc_hdr_credits_o(fcCredits),
        .fc_update_ready_i(fcReady),
        .fc_init_done_o(initDone),
        .overflow_o(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Sample at the falling edge: the scoreboard sees the handshakes that complete at the next rising edge
    task automatic sample();
        @(negedge clk);
        if (rst) begin
            expQ.delete();
            popsSinceReset = 0;
        end else begin
            if (appValid && appReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("sb_unexpected_pop", 1, 0);
                end else begin
                    checkOutput("sb_data", appTlp, expQ.pop_front());
                end
                popsSinceReset++;
            end
            if (tlpValid && tlpReady) begin
                expQ.push_back(tlpData);
            end
            if (fcValid && fcReady) begin
                lastCredits = fcCredits;
            end
        end
    endtask

    function automatic logic [127:0] randTlp();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic applyStimulus(input int n);
        nextCycle();
        tlpValid = 1'b1;
        appReady = 1'b1;
        for (int i = 0; i < n; i++) begin
            tlpData = randTlp();
            sample();
            nextCycle();
        end
        tlpValid = 1'b0;
    endtask

    task automatic waitFc(input int budget, output int waited, output bit found);
        found  = 1'b0;
        waited = 0;
        while (!found && waited < budget) begin
            sample();
            if (fcValid) begin
                found = 1'b1;
            end else begin
                nextCycle();
                waited++;
            end
        end
        if (!found) begin
            checkOutput("fc_wait_timeout", 0, 1);
        end
    endtask

    task automatic resetDut(input logic fcRdy);
        nextCycle();
        rst      = 1'b1;
        tlpValid = 1'b0;
        appReady = 1'b0;
        fcReady  = fcRdy;
        sample();
        nextCycle();
        sample();
        checkOutput("rst_tlp_ready", tlpReady, 0);
        checkOutput("rst_app_valid", appValid, 0);
        checkOutput("rst_app_tlp", appTlp, 0);
        checkOutput("rst_fc_valid", fcValid, 0);
        checkOutput("rst_fc_credits", fcCredits, 0);
        checkOutput("rst_init_done", initDone, 0);
        checkOutput("rst_overflow", overflow, 0);
        nextCycle();
        rst = 1'b0;
        sample();
        checkOutput("init_fc_valid", fcValid, 1);
        checkOutput("init_credits", fcCredits, 8);
        checkOutput("init_done_low", initDone, 0);
        checkOutput("init_tlp_ready", tlpReady, 0);
    endtask

    initial begin
        logic [127:0] dataA, dataB, dataC, ovfData, firstData;
        int n, waited;
        bit found;

        rst       = 1'b1;
        tlpValid  = 1'b0;
        tlpData   = '0;
        appReady  = 1'b0;
        fcReady   = 1'b1;
        dataA     = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
        dataB     = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
        dataC     = 128'hCCCC_0001_CCCC_0002_CCCC_0003_CCCC_0004;
        ovfData   = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
        firstData = '0;

        $display("[TB] reset and initial credit advertisement");
        resetDut(1'b1);
        nextCycle();
        sample();
        checkOutput("init_done_high", initDone, 1);
        checkOutput("init_ready_high", tlpReady, 1);
        checkOutput("init_fc_idle", fcValid, 0);
        checkOutput("init_adv_value", lastCredits, 8);

        $display("[TB] latency and ordering");
        nextCycle();
        appReady = 1'b1;
        tlpValid = 1'b1;
        tlpData  = dataA;
        sample();
        nextCycle();
        tlpData = dataB;
        sample();
        checkOutput("lat_a_valid", appValid, 1);
        checkOutput("lat_a_data", appTlp, dataA);
        nextCycle();
        tlpData = dataC;
        sample();
        checkOutput("ord_b_data", appTlp, dataB);
        nextCycle();
        tlpValid = 1'b0;
        sample();
        checkOutput("ord_c_data", appTlp, dataC);
        nextCycle();
        sample();
        checkOutput("drain_empty", appValid, 0);

        $display("[TB] full, backpressure and overflow");
        nextCycle();
        appReady = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tlpValid = 1'b1;
            tlpData  = randTlp();
            if (i == 0) firstData = tlpData;
            sample();
            checkOutput("fill_ready", tlpReady, 1);
            nextCycle();
        end
        tlpData = ovfData;
        sample();
        checkOutput("full_ready_low", tlpReady, 0);
        checkOutput("full_overflow_pre", overflow, 0);
        nextCycle();
        sample();
        checkOutput("overflow_set", overflow, 1);
        nextCycle();
        tlpValid = 1'b0;
        sample();
        checkOutput("overflow_sticky", overflow, 1);
        checkOutput("head_hold_valid", appValid, 1);
        checkOutput("head_hold_data", appTlp, firstData);
        nextCycle();
        appReady = 1'b1;
        sample();
        checkOutput("ready_same_cycle", tlpReady, 0);
        nextCycle();
        appReady = 1'b0;
        sample();
        checkOutput("ready_next_cycle", tlpReady, 1);
        nextCycle();
        appReady = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            sample();
            if (appValid) n++;
            nextCycle();
        end
        checkOutput("drain_count", n, 7);
        checkOutput("drain_sb_empty", expQ.size(), 0);
        checkOutput("overflow_held", overflow, 1);

        $display("[TB] threshold, timeout and credit wrap");
        resetDut(1'b1);
        nextCycle();
        sample();
        checkOutput("reinit_done", initDone, 1);
        applyStimulus(4);
        waitFc(20, waited, found);
        checkOutput("thresh_credits", fcCredits, 12);
        applyStimulus(1);
        waitFc(120, waited, found);
        checkOutput("timeout_window", (waited >= 60 && waited <= 72), 1);
        checkOutput("timeout_credits", fcCredits, 13);
        applyStimulus(252);
        for (int k = 0; k < 100; k++) begin
            sample();
            nextCycle();
        end
        checkOutput("wrap_credits", lastCredits, 9);
        checkOutput("wrap_pop_total", popsSinceReset, 257);
        checkOutput("wrap_sb_empty", expQ.size(), 0);
        checkOutput("wrap_fc_idle", fcValid, 0);

        $display("[TB] reset during a pending update");
        fcReady = 1'b0;
        applyStimulus(4);
        waitFc(20, waited, found);
        checkOutput("upd_credits", fcCredits, 13);
        applyStimulus(2);
        sample();
        checkOutput("upd_hold_valid", fcValid, 1);
        checkOutput("upd_hold_credits", fcCredits, 13);
        resetDut(1'b0);
        nextCycle();
        sample();
        checkOutput("init_hold_valid", fcValid, 1);
        checkOutput("init_hold_done", initDone, 0);
        nextCycle();
        fcReady = 1'b1;
        sample();
        nextCycle();
        sample();
        checkOutput("final_init_done", initDone, 1);
        checkOutput("final_tlp_ready", tlpReady, 1);
        applyStimulus(1);
        for (int k = 0; k < 3; k++) begin
            sample();
            nextCycle();
        end
        checkOutput("final_sb_empty", expQ.size(), 0);
        checkOutput("final_pops", popsSinceReset, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcie_tl_rx_buf.md
PCIE_TL_RX_BUF -- requirements
Module: pcie_tl_rx_buf

Interface
REQ-001 Parameter TLP_W, default 128: width of one transaction-layer TLP word, equal to PCIe_PKG::PCIe_TL_TLP_PACKET_SIZE.
REQ-002 Parameter DEPTH, default 8: receive buffer entries; power of two, 2..128; one entry equals one header credit.
REQ-003 Parameter UPDATE_THRESH, default 4: freed-credit count, 1..DEPTH, that forces an UpdateFC.
REQ-004 Parameter UPDATE_TIMEOUT, default 64: idle cycles, >=1, after which any nonzero freed credits are advertised.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 tlp_valid_i  in  1  TLP offered by the DLL RX stage.
REQ-008 tlp_i  in  TLP_W  TLP payload from the DLL RX stage.
REQ-009 tlp_ready_o  out  1  buffer can accept a TLP this cycle.
REQ-010 app_valid_o  out  1  head TLP available to the application.
REQ-011 app_tlp_o  out  TLP_W  head TLP.
REQ-012 app_ready_i  in  1  application accepts the head TLP.
REQ-013 fc_update_valid_o  out  1  request to the DLLP TX to send InitFC/UpdateFC.
REQ-014 fc_hdr_credits_o  out  8  cumulative header credits allocated, modulo 256.
REQ-015 fc_update_ready_i  in  1  DLLP TX accepts the FC request.
REQ-016 fc_init_done_o  out  1  initial credit advertisement has completed.
REQ-017 overflow_o  out  1  sticky receiver-overflow error.

Function
REQ-018 A push occurs on tlp_valid_i & tlp_ready_o; a pop occurs on app_valid_o & app_ready_i.
REQ-019 tlp_ready_o = !full & fc_init_done_o, with full derived from the registered occupancy count.
REQ-020 Buffer is FIFO-ordered; app_tlp_o is the oldest entry, driven from registered storage.
REQ-021 Latency: a TLP pushed into an empty buffer appears on app_valid_o/app_tlp_o exactly one cycle later.
REQ-022 app_valid_o and app_tlp_o stay stable while app_valid_o=1 and app_ready_i=0.
REQ-023 Simultaneous push and pop when not full and not empty: occupancy unchanged, both complete.
REQ-024 Pop while full frees the slot, but tlp_ready_o only rises on the following cycle; no same-cycle push.
REQ-025 Pointers wrap modulo DEPTH; the occupancy counter is log2(DEPTH)+1 bits wide.
REQ-026 overflow_o is set when tlp_valid_i=1 while full (a link-partner credit violation); the TLP is dropped and the flag is cleared only by rst.
REQ-027 alloc counter: 8-bit register, initialised to DEPTH mod 256, incremented by 1 per pop, wrapping modulo 256.
REQ-028 pending counter: counts pops not yet advertised; saturates at DEPTH.
REQ-029 idle timer: counts cycles with pending>0 and no UPDATE in progress; cleared on entry to UPDATE.
REQ-030 FSM states: INIT, IDLE, UPDATE.
REQ-031 INIT: assert fc_update_valid_o with fc_hdr_credits_o=DEPTH; on fc_update_ready_i go to IDLE and set fc_init_done_o=1.
REQ-032 IDLE -> UPDATE when pending>=UPDATE_THRESH or idle timer reaches UPDATE_TIMEOUT.
REQ-033 On entry to UPDATE: latch alloc into fc_hdr_credits_o and clear pending, except that a pop in the same cycle leaves pending=1.
REQ-034 UPDATE: fc_update_valid_o=1 with fc_hdr_credits_o held stable; on fc_update_ready_i go to IDLE.
REQ-035 Pops during UPDATE increment alloc and pending, but do not alter fc_hdr_credits_o.
REQ-036 fc_update_valid_o is 0 in IDLE.

Reset
REQ-037 rst=1 (sampled at a clock edge) forces: FSM=INIT, pointers/occupancy/pending/timer=0, alloc=DEPTH, overflow_o=0, fc_init_done_o=0.
REQ-038 Output values during reset: tlp_ready_o=0, app_valid_o=0, app_tlp_o=0, fc_update_valid_o=0, fc_hdr_credits_o=0.
REQ-039 rst mid-operation discards buffered TLPs and any in-flight FC request; the block restarts from INIT on the first cycle after rst deasserts.

Verification
REQ-040 Init: release rst with fc_update_ready_i=1 -> next cycle fc_update_valid_o=1 with credits 8; after handshake, fc_init_done_o=1 and tlp_ready_o=1.
REQ-041 Latency/order: push A,B,C with app_ready_i=1 -> A on app_tlp_o one cycle after its push, then B, then C, no gaps.
REQ-042 Full/backpressure: app_ready_i=0, push 8 -> tlp_ready_o=0; one pop -> tlp_ready_o=1 the next cycle, not the same cycle.
REQ-043 Overflow: drive tlp_valid_i while full -> overflow_o=1 held, occupancy stays 8, stored data unchanged.
REQ-044 Threshold/timeout: 4 pops -> UpdateFC value 12; 1 pop then 64 idle cycles -> UpdateFC value 13; 252 further pops -> value wraps to 9.
REQ-045 Reset mid-UPDATE with fc_update_ready_i=0 -> fc_update_valid_o drops; after rst deasserts, INIT re-advertises 8.
